mdu_hilo: RTL and testbench
===========================

Name: mdu_hilo

Overview:
- Iterative multiply/divide unit for the MIPS datapath. Executes MULT, MULTU, DIV and DIVU over multiple cycles and owns the architectural HI/LO registers.
- It is the sequential counterpart to the single-cycle ALU. The ALU adds, subtracts and shifts in one cycle; this block runs shift-add multiply and restoring division, one bit per cycle.
- It sits beside the ALU in EX. The pipeline stalls on o_busy before issuing MFHI/MFLO or a new mult/div.

Parameters:
- WIDTH, 32, operand width. HI and LO are WIDTH bits each, and an operation takes WIDTH iteration cycles.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_start  in  1  launch an operation. Accepted only when o_busy=0.
- i_op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU. Sampled with i_start.
- i_A  in  WIDTH  multiplicand / dividend (rs). Sampled with i_start.
- i_B  in  WIDTH  multiplier / divisor (rt). Sampled with i_start.
- i_mthi  in  1  write i_wdata into HI (MTHI).
- i_mtlo  in  1  write i_wdata into LO (MTLO).
- i_wdata  in  WIDTH  data for MTHI/MTLO.
- o_busy  out  1  operation in progress.
- o_done  out  1  one-cycle pulse when HI/LO are updated by an operation.
- o_div_zero  out  1  one-cycle pulse coincident with o_done when a DIV/DIVU had divisor 0.
- o_hi  out  WIDTH  HI register.
- o_lo  out  WIDTH  LO register.

Behaviour:
- Reset (i_rst=1 at an edge): state IDLE, HI=LO=0, o_busy=0, o_done=0, o_div_zero=0, iteration counter=0.
- Reset mid-operation aborts the operation; no result is written.
- FSM IDLE:
  - i_start=1 latches operands and op, then goes to CALC with counter=0.
  - For signed ops, operands are converted to magnitudes and the result signs are recorded.
- FSM CALC:
  - One iteration per cycle; the counter increments.
  - Multiply: 2*WIDTH-bit shift-add.
  - Divide: restoring divide, one quotient bit per cycle.
  - On the edge ending iteration WIDTH-1:
    - apply sign correction;
    - write HI/LO;
    - return to IDLE;
    - set o_done=1 for exactly one cycle.
- Latency: start sampled at edge N.
  - o_busy=1 during the WIDTH cycles following edge N.
  - o_done=1 and new HI/LO are visible in cycle N+WIDTH+1, with o_busy=0 in that cycle.
  - A new i_start is accepted in that same cycle (back-to-back).
- Multiply results:
  - {HI,LO} is the full 2*WIDTH-bit product.
  - MULT treats operands as two's complement; MULTU as unsigned.
- Divide results:
  - LO = quotient, HI = remainder.
  - DIV truncates toward zero; the remainder takes the sign of the dividend.
  - DIVU is unsigned.
- Divide by zero:
  - Still takes WIDTH cycles.
  - HI and LO are left unchanged.
  - o_div_zero pulses together with o_done.
- Signed overflow, DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. No flag is raised.
- i_start while o_busy=1: ignored; the operation in flight is unaffected.
- MTHI/MTLO:
  - When IDLE, the register is written at the next edge. i_mthi and i_mtlo may both be asserted.
  - While o_busy=1: ignored.
  - With i_start in the same IDLE cycle: i_start wins, and the move is ignored.
- o_hi/o_lo are driven directly from the registers and hold old values throughout CALC.
- Operands are latched internally, so i_A/i_B may change after the start cycle.

Test Plan:
- Unsigned multiply, full width: MULTU 0xFFFFFFFF x 0xFFFFFFFF.
  - o_busy high exactly 32 cycles.
  - o_done pulses once.
  - HI=0xFFFFFFFE, LO=0x00000001.
- Signed multiply and divide, sign handling:
  - MULT 0xFFFFFFFD (-3) x 7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB.
  - DIV 0xFFFFFFF9 (-7) / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU 100/7 → LO=14, HI=2.
- Divide by zero: MTHI 0x1234 and MTLO 0x5678, then DIVU 7/0.
  - o_div_zero and o_done pulse in the same cycle after 32 busy cycles.
  - HI=0x1234, LO=0x5678.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0, o_div_zero=0.
- Busy-time interference: start MULTU 3x5, then assert i_start (DIVU 9/3) and i_mthi at busy cycle 5.
  - Both are ignored; HI=0, LO=15.
  - A new start in the o_done cycle is accepted, and o_busy rises on the next cycle.
- Reset mid-operation: start MULTU 2x2 with HI/LO=0xAAAA, then i_rst at busy cycle 10.
  - Next cycle: o_busy=0, HI=LO=0.
  - No o_done ever appears for the aborted operation.

Source files
------------

// File: rtl/mdu_hilo.sv
// Iterative MIPS multiply/divide unit owning the HI/LO registers.
// Latency: WIDTH cycles of o_busy after the start edge, results and o_done visible in the following cycle.
// Backpressure: i_start and MTHI/MTLO are ignored while o_busy=1; the pipeline must stall on o_busy.
module mdu_hilo #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_A,
  input  logic [WIDTH-1:0] i_B,
  input  logic             i_mthi,
  input  logic             i_mtlo,
  input  logic [WIDTH-1:0] i_wdata,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_div_zero,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {S_IDLE, S_CALC} state_t;

  state_t r_state, w_state_nxt;

  logic [CW-1:0]      r_cnt;
  logic               r_is_div;
  logic               r_neg_res;  // product sign (mult) or quotient sign (div)
  logic               r_neg_a;    // remainder takes the dividend's sign
  logic               r_dz;
  logic [2*WIDTH-1:0] r_acc;      // mult: running product; div: {remainder, dividend/quotient}
  logic [2*WIDTH-1:0] r_mcand;    // multiplicand, shifted left each iteration
  logic [WIDTH-1:0]   r_b;        // multiplier (shifted right) or divisor (held)
  logic [WIDTH-1:0]   r_hi, r_lo;
  logic               r_done, r_dzp;

  logic               w_start, w_last, w_signed, w_a_neg, w_b_neg;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag;
  logic [2*WIDTH-1:0] w_mul_acc, w_div_acc, w_acc_nxt, w_prod;
  logic [WIDTH:0]     w_shift, w_sub;
  logic [WIDTH-1:0]   w_quo, w_rem, w_hi_res, w_lo_res;

  assign w_start  = (r_state == S_IDLE) && i_start;
  assign w_last   = (r_state == S_CALC) && (r_cnt == LAST);

  // Signed ops run on magnitudes; the signs are reapplied at the end.
  assign w_signed = ~i_op[0];
  assign w_a_neg  = w_signed & i_A[WIDTH-1];
  assign w_b_neg  = w_signed & i_B[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -i_A : i_A;
  assign w_b_mag  = w_b_neg ? -i_B : i_B;

  // One shift-add multiply step and one restoring divide step per cycle.
  assign w_mul_acc = r_b[0] ? (r_acc + r_mcand) : r_acc;
  assign w_shift   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_sub     = w_shift - {1'b0, r_b};
  assign w_div_acc = w_sub[WIDTH] ? {w_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                  : {w_sub[WIDTH-1:0],   r_acc[WIDTH-2:0], 1'b1};
  assign w_acc_nxt = r_is_div ? w_div_acc : w_mul_acc;

  // Sign correction applied to the value produced by the final iteration.
  assign w_prod   = r_neg_res ? -w_acc_nxt : w_acc_nxt;
  assign w_quo    = w_acc_nxt[WIDTH-1:0];
  assign w_rem    = w_acc_nxt[2*WIDTH-1:WIDTH];
  assign w_hi_res = r_is_div ? (r_neg_a ? -w_rem : w_rem) : w_prod[2*WIDTH-1:WIDTH];
  assign w_lo_res = r_is_div ? (r_neg_res ? -w_quo : w_quo) : w_prod[WIDTH-1:0];

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic: start launches CALC, the last iteration returns to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_nxt = S_CALC;
      S_CALC:  if (w_last)  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    o_busy = (r_state == S_CALC);
  end

  // Operand capture, per-cycle iteration and iteration counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt     <= '0;
      r_is_div  <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_a   <= 1'b0;
      r_dz      <= 1'b0;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_b       <= '0;
    end else if (w_start) begin
      r_cnt     <= '0;
      r_is_div  <= i_op[1];
      r_neg_res <= w_a_neg ^ w_b_neg;
      r_neg_a   <= w_a_neg;
      r_dz      <= i_op[1] && (i_B == '0);
      r_acc     <= i_op[1] ? {{WIDTH{1'b0}}, w_a_mag} : '0;
      r_mcand   <= {{WIDTH{1'b0}}, w_a_mag};
      r_b       <= w_b_mag;
    end else if (r_state == S_CALC) begin
      r_cnt   <= r_cnt + CW'(1);
      r_acc   <= w_acc_nxt;
      r_mcand <= r_mcand << 1;
      if (!r_is_div) r_b <= r_b >> 1;
    end
  end

  // HI/LO update: results on completion (skipped on divide by zero), moves only in IDLE without start.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_done <= 1'b0;
      r_dzp  <= 1'b0;
    end else begin
      r_done <= w_last;
      r_dzp  <= w_last && r_dz;
      if (w_last) begin
        if (!r_dz) begin
          r_hi <= w_hi_res;
          r_lo <= w_lo_res;
        end
      end else if ((r_state == S_IDLE) && !i_start) begin
        if (i_mthi) r_hi <= i_wdata;
        if (i_mtlo) r_lo <= i_wdata;
      end
    end
  end

  assign o_done     = r_done;
  assign o_div_zero = r_dzp;
  assign o_hi       = r_hi;
  assign o_lo       = r_lo;

endmodule

// File: tb/tb_mdu_hilo.sv
// Scoreboard bench for mdu_hilo: directed plan cases plus randomized ops against an arithmetic model.
module tb_mdu_hilo;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = '0;
  logic [W-1:0] a = '0, b = '0, wdata = '0;
  logic         mthi = 1'b0, mtlo = 1'b0;
  logic         busy, done, dz;
  logic [W-1:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;

  // {div_zero, hi, lo} expected per completing operation
  logic [2*W:0] exp_q[$];
  logic [W-1:0] m_hi = '0, m_lo = '0;

  mdu_hilo #(.WIDTH(W)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_op(op), .i_A(a), .i_B(b),
    .i_mthi(mthi), .i_mtlo(mtlo), .i_wdata(wdata),
    .o_busy(busy), .o_done(done), .o_div_zero(dz), .o_hi(hi), .o_lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Architectural reference: plain 64-bit arithmetic on the MIPS definitions.
  function automatic logic [2*W:0] ref_model(input logic [1:0] o, input logic [W-1:0] x, y,
                                             input logic [W-1:0] h, l);
    longint sx, sy, ux, uy, p, q, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'({32'h0, x});
    uy = longint'({32'h0, y});
    case (o)
      2'd0: begin p = sx * sy; return {1'b0, p[63:0]}; end
      2'd1: begin p = ux * uy; return {1'b0, p[63:0]}; end
      2'd2: begin
        if (y == 0) return {1'b1, h, l};
        q = sx / sy; r = sx % sy;
        return {1'b0, r[31:0], q[31:0]};
      end
      default: begin
        if (y == 0) return {1'b1, h, l};
        q = ux / uy; r = ux % uy;
        return {1'b0, r[31:0], q[31:0]};
      end
    endcase
  endfunction

  // Monitor: every completion is matched against the oldest expectation.
  always @(negedge clk) begin
    if (done || dz) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: done=%b dz=%b with no operation outstanding", done, dz);
      end else begin
        logic [2*W:0] e;
        e = exp_q.pop_front();
        chk("sb_done", 64'(done), 64'd1);
        chk("sb_div_zero", 64'(dz), 64'(e[2*W]));
        chk("sb_hi", 64'(hi), 64'(e[2*W-1:W]));
        chk("sb_lo", 64'(lo), 64'(e[W-1:0]));
      end
    end
  end

  // Launch an op; a move in the same cycle must lose to the start.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, y, input bit push,
                       input bit with_move);
    logic [2*W:0] e;
    start = 1'b1; op = o; a = x; b = y;
    if (with_move) begin mthi = 1'b1; mtlo = 1'b1; wdata = $urandom; end
    if (push) begin
      e = ref_model(o, x, y, m_hi, m_lo);
      exp_q.push_back(e);
      m_hi = e[2*W-1:W];
      m_lo = e[W-1:0];
    end
    @(posedge clk); #1;
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    a = $urandom; b = $urandom;  // operands must have been latched
  endtask

  task automatic do_move(input bit h, input bit l, input logic [W-1:0] d);
    mthi = h; mtlo = l; wdata = d;
    @(posedge clk); #1;
    mthi = 1'b0; mtlo = 1'b0;
    if (h) m_hi = d;
    if (l) m_lo = d;
  endtask

  // Count busy cycles up to the done cycle; optionally inject start+mthi at busy cycle 5.
  task automatic wait_done(input string name, input bit interfere, input bit skip_first);
    int cnt;
    cnt = 0;
    if (!skip_first) @(negedge clk);
    while (busy && cnt < 100) begin
      cnt++;
      if (interfere && cnt == 5) begin
        start = 1'b1; op = 2'd3; a = 32'd9; b = 32'd3; mthi = 1'b1; wdata = 32'hDEAD;
      end
      @(negedge clk);
      if (interfere && cnt == 5) begin start = 1'b0; mthi = 1'b0; end
    end
    chk({name, "_busy_cycles"}, 64'(cnt), 64'd32);
    chk({name, "_done_pulse"}, 64'(done), 64'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    logic [1:0] ro;
    logic [W-1:0] ra, rb;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_dz", 64'(dz), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);

    issue(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0);
    wait_done("multu_max", 0, 0);
    @(negedge clk);
    chk("multu_max_done_once", 64'(done), 64'd0);
    chk("multu_max_hi", 64'(hi), 64'hFFFFFFFE);
    chk("multu_max_lo", 64'(lo), 64'h00000001);

    issue(2'd0, 32'hFFFFFFFD, 32'd7, 1, 0);
    wait_done("mult_neg", 0, 0);
    chk("mult_neg_hi", 64'(hi), 64'hFFFFFFFF);
    chk("mult_neg_lo", 64'(lo), 64'hFFFFFFEB);

    issue(2'd2, 32'hFFFFFFF9, 32'd2, 1, 0);
    wait_done("div_neg", 0, 0);
    chk("div_neg_hi", 64'(hi), 64'hFFFFFFFF);
    chk("div_neg_lo", 64'(lo), 64'hFFFFFFFD);

    issue(2'd3, 32'd100, 32'd7, 1, 0);
    wait_done("divu", 0, 0);
    chk("divu_hi", 64'(hi), 64'd2);
    chk("divu_lo", 64'(lo), 64'd14);

    do_move(1, 0, 32'h1234);
    do_move(0, 1, 32'h5678);
    issue(2'd3, 32'd7, 32'd0, 1, 0);
    wait_done("divz", 0, 0);
    chk("divz_flag", 64'(dz), 64'd1);
    chk("divz_hi", 64'(hi), 64'h1234);
    chk("divz_lo", 64'(lo), 64'h5678);

    issue(2'd2, 32'h80000000, 32'hFFFFFFFF, 1, 0);
    wait_done("div_ovf", 0, 0);
    chk("div_ovf_flag", 64'(dz), 64'd0);
    chk("div_ovf_hi", 64'(hi), 64'd0);
    chk("div_ovf_lo", 64'(lo), 64'h80000000);

    issue(2'd1, 32'd3, 32'd5, 1, 0);
    wait_done("interf", 1, 0);
    chk("interf_hi", 64'(hi), 64'd0);
    chk("interf_lo", 64'(lo), 64'd15);
    issue(2'd3, 32'd9, 32'd3, 1, 0);  // issued in the done cycle
    @(negedge clk);
    chk("b2b_busy_rises", 64'(busy), 64'd1);
    wait_done("b2b", 0, 1);
    chk("b2b_lo", 64'(lo), 64'd3);

    // Randomized ops, some back-to-back, some with a losing same-cycle move.
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) ra = 32'h80000000;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(0, 9));
      if ($urandom_range(0, 2) == 0)
        do_move(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      issue(ro, ra, rb, 1, 1'($urandom_range(0, 3) == 0));
      wait_done("rand", 0, 0);
    end

    do_move(1, 1, 32'hAAAA);
    issue(2'd1, 32'd2, 32'd2, 0, 0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_hi = '0; m_lo = '0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_hi", 64'(hi), 64'd0);
    chk("abort_lo", 64'(lo), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("abort_no_done", 64'(seen), 64'd0);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
